// File: rtl/trng_collector.sv
// trng_collector: repetition-tested, von Neumann debiased byte collector.
// Ports: clk, rst_n, run, clear_fail, number[7:0] in; enabled, out_data[7:0],
// out_valid, health_fail out; out_ready in (valid/ready byte stream).
module trng_collector #(
  parameter int WARMUP    = 16,
  parameter int REP_LIMIT = 4,
  parameter int DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear_fail,
  input  logic [7:0] number,
  output logic       enabled,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       health_fail
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_WARMUP, S_COLLECT, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [RW-1:0] rep_q, rep_d, rep_nx;
  logic [7:0]    prev_q, prev_d;
  logic [10:0]   acc_q, acc_d, merged;
  logic [3:0]    acc_cnt_q, acc_cnt_d, sum;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enabled_q, enabled_d;
  logic          fail_q, fail_d;
  logic          sample, trip, push, pop;
  logic [3:0]    nvec;
  logic [2:0]    nbits;

  // Unequal pairs emit their upper bit, compacted LSB-first.
  always_comb begin
    nvec  = '0;
    nbits = '0;
    for (int i = 0; i < 4; i++) begin
      if (number[2*i+1] != number[2*i]) begin
        nvec[nbits[1:0]] = number[2*i+1];
        nbits = nbits + 3'd1;
      end
    end
  end

  assign merged = acc_q | (11'(nvec) << acc_cnt_q);
  assign sum    = acc_cnt_q + 4'(nbits);

  // rep_q == 0 means no previous sample since the last stop.
  always_comb begin
    if (rep_q == '0 || number != prev_q) begin
      rep_nx = RW'(1);
    end else if (rep_q == RW'(REP_LIMIT)) begin
      rep_nx = rep_q;
    end else begin
      rep_nx = rep_q + RW'(1);
    end
  end

  assign sample = (state_q == S_WARMUP) ||
                  (state_q == S_COLLECT && cnt_q < CW'(DEPTH));
  assign trip   = sample && (rep_nx == RW'(REP_LIMIT));
  assign pop    = (cnt_q != '0) && out_ready;

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    rep_d     = rep_q;
    prev_d    = prev_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    push      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_WARMUP;
          warm_d  = '0;
        end
      end
      S_WARMUP, S_COLLECT: begin
        if (sample) begin
          rep_d  = rep_nx;
          prev_d = number;
        end
        if (trip) begin
          state_d = S_FAIL;
        end else if (!run) begin
          state_d   = S_IDLE;
          rep_d     = '0;
          acc_d     = '0;
          acc_cnt_d = '0;
        end else if (state_q == S_WARMUP) begin
          warm_d = warm_q + WW'(1);
          if (warm_q == WW'(WARMUP - 1)) state_d = S_COLLECT;
        end else if (sample) begin
          if (sum >= 4'd8) begin
            push      = 1'b1;
            acc_d     = merged >> 8;
            acc_cnt_d = sum - 4'd8;
          end else begin
            acc_d     = merged;
            acc_cnt_d = sum;
          end
        end
      end
      S_FAIL: begin
        if (clear_fail) begin
          state_d   = S_IDLE;
          rep_d     = '0;
          acc_d     = '0;
          acc_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Push only happens below DEPTH, so no overflow guard is needed.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = merged[7:0];
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  assign enabled_d = (state_d == S_WARMUP) || (state_d == S_COLLECT);
  assign fail_d    = (state_d == S_FAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      warm_q    <= '0;
      rep_q     <= '0;
      prev_q    <= '0;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      enabled_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      rep_q     <= rep_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      enabled_q <= enabled_d;
      fail_q    <= fail_d;
    end
  end

  assign enabled     = enabled_q;
  assign health_fail = fail_q;
  assign out_valid   = (cnt_q != '0);
  assign out_data    = mem_q[rd_q];

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: scenario tasks against a queue-based behavioural model.
// Drives trng_collector with directed and $urandom stimulus.
module tb_trng_collector;
  localparam int WARMUP    = 16;
  localparam int REP_LIMIT = 4;
  localparam int DEPTH     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       clear_fail = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] number = 8'h00;
  logic       enabled, out_valid, health_fail;
  logic [7:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  // model: 0 idle, 1 warmup, 2 collect, 3 fail
  int         m_mode, m_warm, m_rep;
  logic [7:0] m_prev;
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  logic [7:0] m_popped[$];
  logic [7:0] got_q[$];

  trng_collector #(
    .WARMUP(WARMUP), .REP_LIMIT(REP_LIMIT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear_fail(clear_fail),
    .number(number), .enabled(enabled), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0;
    m_warm = 0;
    m_rep  = 0;
    m_prev = 8'h00;
    m_bits.delete();
    m_fifo.delete();
    m_popped.delete();
    got_q.delete();
  endfunction

  function automatic void model_step();
    bit         smp, pop, psh;
    logic [7:0] pb;
    int         nr;
    pop = (m_fifo.size() > 0) && out_ready;
    smp = (m_mode == 1) || (m_mode == 2 && m_fifo.size() < DEPTH);
    psh = 0;
    pb  = 8'h00;
    nr  = m_rep;
    if (smp) begin
      if (m_rep > 0 && number == m_prev)
        nr = (m_rep < REP_LIMIT) ? m_rep + 1 : REP_LIMIT;
      else
        nr = 1;
    end
    case (m_mode)
      0: if (run) begin m_mode = 1; m_warm = 0; end
      1, 2: begin
        if (smp) begin m_rep = nr; m_prev = number; end
        if (smp && nr == REP_LIMIT) m_mode = 3;
        else if (!run) begin
          m_mode = 0; m_rep = 0; m_bits.delete();
        end else if (m_mode == 1) begin
          m_warm++;
          if (m_warm == WARMUP) m_mode = 2;
        end else if (smp) begin
          for (int i = 0; i < 4; i++)
            if (number[2*i+1] != number[2*i])
              m_bits.push_back(number[2*i+1]);
          if (m_bits.size() >= 8) begin
            psh = 1;
            for (int j = 0; j < 8; j++) pb[j] = m_bits.pop_front();
          end
        end
      end
      default: if (clear_fail) begin
        m_mode = 0; m_rep = 0; m_bits.delete();
      end
    endcase
    if (pop) m_popped.push_back(m_fifo.pop_front());
    if (psh) m_fifo.push_back(pb);
  endfunction

  task automatic cycle();
    if (out_valid && out_ready) got_q.push_back(out_data);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    run = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH + 4 && m_fifo.size() > 0; k++) cycle();
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (enabled !== 1'b0) begin
      n_fail++; $display("FAIL rst_enabled got %b want 0", enabled);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_data got %h want 00", out_data);
    end
    n_checks++;
    if (health_fail !== 1'b0) begin
      n_fail++; $display("FAIL rst_hfail got %b want 0", health_fail);
    end
    model_reset();
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_byte();
    got_q.delete(); m_popped.delete();
    out_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 19; i++) begin
      number = (i % 2) ? 8'h99 : 8'h66;
      cycle();
      if (i == 0) begin
        n_checks++;
        if (enabled !== 1'b1) begin
          n_fail++; $display("FAIL fb_enabled got %b want 1", enabled);
        end
      end
      if (i == 17) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL fb_valid_early got %b want 0", out_valid);
        end
      end
      if (i == 18) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL fb_valid got %b want 1", out_valid);
        end
        n_checks++;
        if (out_data !== 8'h5A) begin
          n_fail++; $display("FAIL fb_data got %h want 5a", out_data);
        end
      end
    end
    drain();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL fb_drain got %0d bytes want one 5a", got_q.size());
    end
  endtask

  task automatic test_health();
    got_q.delete(); m_popped.delete();
    number = 8'h00;
    run = 1'b1;
    cycle();
    for (int k = 1; k <= REP_LIMIT; k++) begin
      cycle();
      if (k == REP_LIMIT - 1) begin
        n_checks++;
        if (health_fail !== 1'b0) begin
          n_fail++; $display("FAIL hf_early got %b want 0", health_fail);
        end
      end
    end
    n_checks++;
    if (health_fail !== 1'b1) begin
      n_fail++; $display("FAIL hf_trip got %b want 1", health_fail);
    end
    n_checks++;
    if (enabled !== 1'b0) begin
      n_fail++; $display("FAIL hf_enabled got %b want 0", enabled);
    end
    run = 1'b0;
    cycle(); cycle();
    n_checks++;
    if (health_fail !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hf_hold got %b/%b want 1/0", health_fail, out_valid);
    end
    clear_fail = 1'b1;
    cycle();
    clear_fail = 1'b0;
    n_checks++;
    if (health_fail !== 1'b0 || enabled !== 1'b0) begin
      n_fail++;
      $display("FAIL hf_clear got %b/%b want 0/0", health_fail, enabled);
    end
  endtask

  task automatic test_fifo_full();
    got_q.delete(); m_popped.delete();
    out_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 1 + WARMUP + 2 * DEPTH + 6; i++) begin
      number = (i % 2) ? 8'h99 : 8'h66;
      cycle();
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || enabled !== 1'b1) begin
      n_fail++;
      $display("FAIL ff_stall got v%b d%h e%b want v1 d5a e1",
               out_valid, out_data, enabled);
    end
    drain();
    n_checks++;
    if (got_q.size() != DEPTH) begin
      n_fail++; $display("FAIL ff_count got %0d want %0d", got_q.size(), DEPTH);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== 8'h5A) begin
        n_fail++; $display("FAIL ff_byte%0d got %h want 5a", k, got_q[k]);
      end
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ff_empty got %b want 0", out_valid);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] seq [7];
    seq = '{8'hAA, 8'h55, 8'hAA, 8'h0F, 8'h55, 8'h0F, 8'hAA};
    got_q.delete(); m_popped.delete();
    out_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 1 + WARMUP; i++) begin
      number = (i % 2) ? 8'h99 : 8'h66;
      cycle();
    end
    for (int i = 0; i < 7; i++) begin
      number = seq[i];
      cycle();
      if (i == 0) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL pt_valid_early got %b want 0", out_valid);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F) begin
          n_fail++;
          $display("FAIL pt_first got v%b d%h want v1 d0f", out_valid, out_data);
        end
      end
    end
    drain();
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL pt_count got %0d want 2", got_q.size());
    end
    for (int k = 0; k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== 8'h0F) begin
        n_fail++; $display("FAIL pt_byte%0d got %h want 0f", k, got_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); m_popped.delete();
    out_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 1 + WARMUP + 40; i++) begin
      number = 8'($urandom);
      cycle();
    end
    for (int i = 0; i < 100; i++) begin
      number = 8'($urandom);
      out_ready = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle();
      n_checks++;
      if (out_valid !== (m_fifo.size() != 0)) begin
        n_fail++;
        $display("FAIL bb_valid cyc%0d got %b want %b",
                 i, out_valid, m_fifo.size() != 0);
      end else if (m_fifo.size() != 0 && out_data !== m_fifo[0]) begin
        n_fail++;
        $display("FAIL bb_head cyc%0d got %h want %h", i, out_data, m_fifo[0]);
      end
    end
    drain();
    n_checks++;
    if (got_q.size() != m_popped.size()) begin
      n_fail++;
      $display("FAIL bb_count got %0d want %0d", got_q.size(), m_popped.size());
    end
    for (int k = 0; k < got_q.size() && k < m_popped.size(); k++) begin
      n_checks++;
      if (got_q[k] !== m_popped[k]) begin
        n_fail++;
        $display("FAIL bb_byte%0d got %h want %h", k, got_q[k], m_popped[k]);
      end
    end
    clear_fail = 1'b1;
    cycle();
    clear_fail = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [6];
    seq = '{8'h99, 8'h66, 8'h99, 8'h66, 8'h99, 8'h01};
    got_q.delete(); m_popped.delete();
    out_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 1 + WARMUP; i++) begin
      number = (i % 2) ? 8'h99 : 8'h66;
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      number = seq[i];
      cycle();
    end
    n_checks++;
    if (out_valid !== 1'b1 || enabled !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre got v%b e%b want v1 e1", out_valid, enabled);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rm_fifo got v%b d%h want v0 d00", out_valid, out_data);
    end
    n_checks++;
    if (enabled !== 1'b0 || health_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_ctrl got e%b h%b want e0 h0", enabled, health_fail);
    end
    model_reset();
    run = 1'b0;
    #3 rst_n = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 1 + WARMUP; i++) begin
      number = (i % 2) ? 8'h99 : 8'h66;
      cycle();
    end
    number = 8'hAA;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_stale got %b want 0", out_valid);
    end
    number = 8'h55;
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0F) begin
      n_fail++;
      $display("FAIL rm_fresh got v%b d%h want v1 d0f", out_valid, out_data);
    end
    drain();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h0F) begin
      n_fail++;
      $display("FAIL rm_drain got %0d bytes want one 0f", got_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_byte();
    test_health();
    test_fifo_full();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
